// File: rtl/dg0045_pkg.sv
// Shared constants and types for the DG0045 program-memory responder.
package dg0045_pkg;

   // Instruction byte width on the core ROM port.
   localparam int DATA_W = 8;

   // Width of one multiplexed address half on PC_HL.
   localparam int HALF_W = 5;

   // Fetch-sequencer phases: upper half presented, then lower half.
   localparam logic [2:0] PH_HI = 3'd2;
   localparam logic [2:0] PH_LO = 3'd3;

   // Idle / reset instruction byte.
   localparam logic [DATA_W-1:0] NOP = 8'h00;

   // Responder operating mode.
   typedef enum logic [1:0] {
      RUN     = 2'd0,
      LOAD    = 2'd1,
      RELEASE = 2'd2
   } state_t;

endpackage : dg0045_pkg

// File: rtl/dg0045_prog_mem.sv
// Program memory: one synchronous write port for the loader, one
// asynchronous read port so the fetch byte is valid in the same cycle
// the lower address half arrives.
module dg0045_prog_mem
   import dg0045_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [2**ADDR_W];

   // Loader write port.
   // NOTE: the array deliberately has no reset; contents must survive a
   // RESET pulse, and a reset would stop it mapping onto RAM.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule : dg0045_prog_mem

// File: rtl/dg0045_rom_responder.sv
// ROM-port responder for the DG0045 4-bit core. Tracks the core clock
// divider with a 3-bit phase counter, captures the two multiplexed
// address halves and serves the instruction byte. A byte-stream loader
// fills program memory while the core is held in reset and releases it
// in phase with the fetch sequencer.
module dg0045_rom_responder
   import dg0045_pkg::*;
#(
   parameter int                ADDR_W     = 10,
   parameter logic [DATA_W-1:0] RESET_BYTE = NOP
) (
   input  logic              clk,
   input  logic              RESET,
   output logic              core_nreset,
   output logic              PC_MUX,
   input  logic [HALF_W-1:0] PC_HL,
   output logic [DATA_W-1:0] mainROM,
   input  logic              ld_start,
   input  logic              ld_valid,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              ld_last,
   output logic              ld_ready,
   output logic              ld_busy
);

   // Upper address part: {PU,PL[5]} for the default 10-bit address.
   localparam int HI_W = ADDR_W - HALF_W;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [2:0]          r_ph;
   logic [2:0]          w_ph_nxt;
   logic [ADDR_W-1:0]   r_ptr;
   logic [ADDR_W-1:0]   w_ptr_nxt;
   logic [HI_W-1:0]     r_hi;
   logic [DATA_W-1:0]   r_rom_q;
   logic                r_core_nreset;
   logic                r_pc_mux;
   logic                w_mem_we;
   logic                w_ld_ready;
   logic                w_ld_busy;
   logic                w_fetch_hi;
   logic                w_fetch_lo;
   logic [ADDR_W-1:0]   w_rd_addr;
   logic [DATA_W-1:0]   w_rd_data;

   // Mode register.
   // NOTE: clocked blocks use non-blocking assignments only, so every
   // register samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         r_state <= RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next mode, load pointer, memory write strobe and loader handshake.
   // NOTE: every output of this block is given a default first so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_mem_we    = 1'b0;
      w_ld_ready  = 1'b0;
      w_ld_busy   = 1'b1;
      case (r_state)
         RUN: begin
            w_ld_busy = 1'b0;
            if (ld_start) begin
               w_state_nxt = LOAD;
               w_ptr_nxt   = '0;
            end
         end
         LOAD: begin
            w_ld_ready = 1'b1;
            if (ld_start) begin
               // Restart takes priority; a byte offered alongside it is dropped.
               w_ptr_nxt = '0;
            end else if (ld_valid) begin
               w_mem_we  = 1'b1;
               // Natural wrap at the top of memory; old bytes are overwritten.
               w_ptr_nxt = r_ptr + ADDR_W'(1);
               if (ld_last) begin
                  w_state_nxt = RELEASE;
               end
            end
         end
         RELEASE: begin
            w_state_nxt = RUN;
         end
         default: begin
            w_state_nxt = RUN;
         end
      endcase
   end

   // The phase counter only runs while the core runs; it sits at 0 on the
   // edge that releases the core, so ph=0 lines up with divider count 0.
   assign w_ph_nxt = ((r_state == RUN) && (w_state_nxt == RUN) && r_core_nreset)
                     ? r_ph + 3'd1 : 3'd0;

   assign w_fetch_hi = (r_state == RUN) && (r_ph == PH_HI);
   assign w_fetch_lo = (r_state == RUN) && (r_ph == PH_LO);
   assign w_rd_addr  = {r_hi, PC_HL};

   // Phase counter, load pointer, core reset, address select, captured
   // upper address and registered instruction byte.
   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         r_ph          <= 3'd0;
         r_ptr         <= '0;
         r_hi          <= '0;
         r_rom_q       <= RESET_BYTE;
         r_pc_mux      <= 1'b0;
         r_core_nreset <= 1'b0;
      end else begin
         r_ph          <= w_ph_nxt;
         r_ptr         <= w_ptr_nxt;
         r_pc_mux      <= (w_ph_nxt == PH_HI);
         r_core_nreset <= (w_state_nxt == RUN);
         if (w_fetch_hi) begin
            r_hi <= PC_HL[HI_W-1:0];
         end
         if (w_fetch_lo) begin
            r_rom_q <= w_rd_data;
         end
      end
   end

   dg0045_prog_mem #(
      .ADDR_W (ADDR_W)
   ) u_prog_mem (
      .clk     (clk),
      .i_we    (w_mem_we),
      .i_waddr (r_ptr),
      .i_wdata (ld_data),
      .i_raddr (w_rd_addr),
      .o_rdata (w_rd_data)
   );

   // During ph=3 the byte flows straight through from memory so the core
   // can latch it on the edge ending F1; otherwise the held copy is shown.
   assign mainROM     = w_fetch_lo ? w_rd_data : r_rom_q;
   assign PC_MUX      = r_pc_mux;
   assign core_nreset = r_core_nreset;
   assign ld_ready    = w_ld_ready;
   assign ld_busy     = w_ld_busy;

endmodule : dg0045_rom_responder

// File: tb/tb_dg0045_rom_responder.sv
// Bench for dg0045_rom_responder: a model core fetches from random or
// planned addresses and queues the byte it expects; a monitor pops and
// compares whenever the core's own divider reaches the fetch phase.
module tb_dg0045_rom_responder;

   localparam int MEM_N = 1024;

   logic       clk = 1'b0;
   logic       RESET;
   logic       core_nreset;
   logic       PC_MUX;
   logic [4:0] PC_HL;
   logic [7:0] mainROM;
   logic       ld_start;
   logic       ld_valid;
   logic [7:0] ld_data;
   logic       ld_last;
   logic       ld_ready;
   logic       ld_busy;

   always #5 clk = ~clk;

   dg0045_rom_responder dut (
      .clk         (clk),
      .RESET       (RESET),
      .core_nreset (core_nreset),
      .PC_MUX      (PC_MUX),
      .PC_HL       (PC_HL),
      .mainROM     (mainROM),
      .ld_start    (ld_start),
      .ld_valid    (ld_valid),
      .ld_data     (ld_data),
      .ld_last     (ld_last),
      .ld_ready    (ld_ready),
      .ld_busy     (ld_busy)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference program image, written linearly as the loader should.
   logic [7:0] m_mem   [MEM_N];
   bit         m_known [MEM_N];
   int         m_ptr = 0;

   typedef struct {
      bit         known;
      logic [7:0] data;
      int         addr;
   } exp_t;

   exp_t exp_q  [$];
   int   plan_q [$];
   int   cnt  = -1;   // model core divider count, -1 while held in reset
   int   pops = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model core: divider restarts at 0 the cycle after nreset rises; puts
   // {PU,PL[5]} on PC_HL during count 2 and PL[4:0] during count 3.
   initial begin : core_model
      logic [9:0] cur_pc;
      exp_t       e;
      cur_pc = '0;
      PC_HL  = '0;
      forever begin
         @(posedge clk);
         #1;
         if (core_nreset !== 1'b1) begin
            cnt = -1;
            exp_q.delete();
         end else begin
            cnt = (cnt < 0) ? 0 : (cnt + 1) % 8;
         end
         if (cnt == 2) begin
            if (plan_q.size() > 0) cur_pc = 10'(plan_q.pop_front());
            else                   cur_pc = 10'($urandom_range(0, MEM_N - 1));
            PC_HL   = cur_pc[9:5];
            e.known = m_known[cur_pc];
            e.data  = m_mem[cur_pc];
            e.addr  = int'(cur_pc);
            exp_q.push_back(e);
         end else if (cnt == 3) begin
            PC_HL = cur_pc[4:0];
         end else begin
            PC_HL = 5'($urandom);
         end
      end
   end

   // Monitor: address select pulse, fetched byte and its hold afterwards.
   initial begin : monitor
      exp_t       e;
      logic [7:0] last;
      bit         have_last;
      have_last = 0;
      last      = '0;
      forever begin
         @(negedge clk);
         if (core_nreset !== 1'b1 || cnt < 0) begin
            check("pc_mux_idle", PC_MUX, 0);
            have_last = 0;
         end else begin
            check($sformatf("pc_mux_ph%0d", cnt), PC_MUX, (cnt == 2) ? 1 : 0);
            if (cnt == 3) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL fetch_no_expectation: fetch phase with empty queue at %0t", $time);
               end else begin
                  e = exp_q.pop_front();
                  pops++;
                  if (e.known) begin
                     check($sformatf("fetch@%03h", e.addr), mainROM, e.data);
                     last      = e.data;
                     have_last = 1;
                  end else begin
                     have_last = 0;
                  end
               end
            end else if (have_last) begin
               check($sformatf("rom_hold_ph%0d", cnt), mainROM, last);
            end
         end
      end
   end

   // Start a load from RUN; optionally offer a byte in the same cycle,
   // which must be dropped.
   task automatic begin_load(input bit junk_valid);
      ld_start = 1'b1;
      ld_valid = junk_valid;
      ld_data  = 8'hEE;
      ld_last  = 1'b0;
      @(negedge clk);
      check("ready_before_load", ld_ready, 0);
      check("busy_before_load", ld_busy, 0);
      tick();
      ld_start = 1'b0;
      ld_valid = 1'b0;
      m_ptr    = 0;
   endtask

   task automatic send_byte(input logic [7:0] d, input bit last);
      ld_valid = 1'b1;
      ld_data  = d;
      ld_last  = last;
      @(negedge clk);
      check("ld_ready_in_load", ld_ready, 1);
      check("ld_busy_in_load", ld_busy, 1);
      check("core_held_in_load", core_nreset, 0);
      tick();
      m_mem[m_ptr]   = d;
      m_known[m_ptr] = 1'b1;
      m_ptr          = (m_ptr + 1) % MEM_N;
      ld_valid       = 1'b0;
      ld_last        = 1'b0;
   endtask

   // Cycle after the last byte: still held; one cycle later the core runs.
   task automatic finish_release();
      @(negedge clk);
      check("release_busy", ld_busy, 1);
      check("release_ready", ld_ready, 0);
      check("release_core_held", core_nreset, 0);
      tick();
      @(negedge clk);
      check("restart_core_nreset", core_nreset, 1);
      check("restart_busy", ld_busy, 0);
   endtask

   task automatic wait_pops(input int n);
      int target;
      int budget;
      target = pops + n;
      budget = n * 8 + 32;
      while (pops < target && budget > 0) begin
         tick();
         budget--;
      end
      check("fetch_budget", (pops >= target) ? 1 : 0, 1);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      RESET    = 1'b0;
      ld_start = 1'b0;
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      ld_data  = '0;

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_mainROM", mainROM, 8'h00);
      check("rst_pc_mux", PC_MUX, 0);
      check("rst_core_nreset", core_nreset, 0);
      check("rst_ld_ready", ld_ready, 0);
      check("rst_ld_busy", ld_busy, 0);

      // Release; core runs from the first edge, PC_MUX first high after edge 3.
      tick();
      RESET = 1'b1;
      tick();
      check("nreset_first_edge", core_nreset, 1);
      tick();
      check("pc_mux_edge2", PC_MUX, 0);
      tick();
      check("pc_mux_edge3", PC_MUX, 1);
      tick();
      check("pc_mux_edge4", PC_MUX, 0);
      repeat (20) tick();

      // Three-byte load, with a byte offered in the start cycle.
      begin_load(1'b1);
      send_byte(8'h4A, 1'b0);
      send_byte(8'h0C, 1'b0);
      send_byte(8'hFF, 1'b1);
      plan_q.push_back(0);
      plan_q.push_back(2);
      finish_release();
      wait_pops(2);

      // Full wrap: 1025 bytes, byte n = n[7:0], except 0x3E1 carries C5.
      begin_load(1'b0);
      for (int n = 0; n <= MEM_N; n++) begin
         send_byte((n == 'h3E1) ? 8'hC5 : 8'(n), (n == MEM_N) ? 1'b1 : 1'b0);
      end
      plan_q.push_back('h3E1);
      plan_q.push_back(0);
      plan_q.push_back(1);
      plan_q.push_back('h3FF);
      finish_release();
      wait_pops(4);
      wait_pops(12);

      // Restart after five bytes; the byte offered with ld_start is dropped.
      begin_load(1'b0);
      for (int n = 0; n < 5; n++) send_byte(8'h10 + 8'(n), 1'b0);
      ld_start = 1'b1;
      ld_valid = 1'b1;
      ld_data  = 8'h77;
      @(negedge clk);
      check("ready_at_restart", ld_ready, 1);
      tick();
      ld_start = 1'b0;
      ld_valid = 1'b0;
      m_ptr    = 0;
      send_byte(8'h5A, 1'b1);
      plan_q.push_back(0);
      plan_q.push_back(5);
      plan_q.push_back(1);
      plan_q.push_back(4);
      finish_release();
      wait_pops(4);

      // Asynchronous RESET in the middle of a load.
      begin_load(1'b0);
      send_byte(8'hA1, 1'b0);
      send_byte(8'hB2, 1'b0);
      #3;
      RESET = 1'b0;
      #1;
      check("abort_core_nreset", core_nreset, 0);
      check("abort_busy", ld_busy, 0);
      check("abort_ready", ld_ready, 0);
      check("abort_pc_mux", PC_MUX, 0);
      check("abort_mainROM", mainROM, 8'h00);
      tick();
      RESET = 1'b1;
      plan_q.push_back(0);
      plan_q.push_back(1);
      plan_q.push_back(2);
      plan_q.push_back(7);
      tick();
      check("abort_restart_nreset", core_nreset, 1);
      check("abort_restart_busy", ld_busy, 0);
      wait_pops(4);

      // Random fetches over the fully known image.
      wait_pops(24);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_dg0045_rom_responder
